l2_write_buffer: RTL
====================

Name: l2_write_buffer

Overview:
- Posted-write buffer between the L2 cache's memory-side request port and the main Memory model.
- Accepts L2 line writebacks into a small FIFO, acknowledges them without waiting for Memory, and drains them to Memory in the background.
- Services L2 line reads from Memory. A read whose line address matches a buffered write is forwarded from the buffer, which keeps memory coherent.

Parameters:
- DEPTH, 4, number of line entries; power of two, 2..16.
- LINE_W, 128, line width in bits (4 x 32-bit words).
- OFFS_W, 4, byte-offset bits dropped for line-address compare.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- up_valid_i  in  1  L2 request valid; held with its fields until up_ready_o.
- up_rw_i  in  1  1 = write (writeback), 0 = read (line fill).
- up_addr_i  in  32  request byte address.
- up_wdata_i  in  LINE_W  write line data.
- up_ready_o  out  1  one-cycle completion pulse to L2.
- up_rdata_o  out  LINE_W  read data; valid while up_ready_o=1 for a read.
- mem_valid_o  out  1  request to Memory.
- mem_rw_o  out  1  1 = write.
- mem_addr_o  out  32  line-aligned address (low OFFS_W bits zero).
- mem_wdata_o  out  LINE_W  write data.
- mem_ready_i  in  1  Memory completion pulse.
- mem_rdata_i  in  LINE_W  Memory read data, valid with mem_ready_i.
- full_o  out  1  count == DEPTH.
- empty_o  out  1  count == 0.
- no_write_o  out  32  writes accepted (optional feature).
- no_coalesce_o  out  32  writes merged into an existing entry (optional feature).
- no_fwd_o  out  32  reads forwarded from the buffer (optional feature).

Behaviour:
- Reset: clocked with clk_i; rst_i is asynchronous and active-high.
  - Asserting rst_i, including mid-transaction, clears all entries and the counters, and returns the FSM to IDLE.
  - Outputs at reset: up_ready_o=0, up_rdata_o=0, mem_valid_o=0, mem_rw_o=0, mem_addr_o=0, mem_wdata_o=0, full_o=0, empty_o=1, stats=0.
  - An in-flight Memory transaction is abandoned.
- Storage: circular FIFO of {line_addr[31:OFFS_W], data} with head/tail pointers wrapping modulo DEPTH, plus a count of width clog2(DEPTH)+1.
- The upstream handshake is level/pulse: up_ready_o pulses exactly one cycle per request. L2 drops up_valid_i the cycle after the pulse.
  - A request is never accepted twice: an internal busy flag blocks re-sampling during the pulse cycle.
- Write, when the line address matches a buffered entry: data is overwritten in place (coalesce); count is unchanged. up_ready_o pulses the next cycle.
  - If the matching entry is the head and currently being drained to Memory, it is not coalesced. The write is instead treated as a new entry.
- Write, no match and not full: enqueue at tail; up_ready_o pulses the next cycle (latency 1).
- Write, no match and full (count is registered; a dequeue in the same cycle does not free space): not accepted; up_ready_o stays 0 until a slot frees.
- Read, match: up_rdata_o = data of the youngest matching entry; up_ready_o pulses the next cycle. No Memory access.
- Read, no match: forwarded to Memory as a READ transaction. up_ready_o pulses the cycle after mem_ready_i, with up_rdata_o = captured mem_rdata_i. Total latency is Memory latency + 1.
- FSM states IDLE, DRAIN, READ, GAP:
  - IDLE -> READ when an unmatched read is pending; reads have priority over draining.
  - IDLE -> DRAIN when not empty and no read is pending.
  - DRAIN: mem_valid_o=1, mem_rw_o=1, and head fields are held stable. On mem_ready_i the head is popped and the FSM goes to GAP.
  - READ: mem_valid_o=1, mem_rw_o=0, and the address is held. On mem_ready_i the data is captured and the FSM goes to GAP.
  - GAP: mem_valid_o=0 for exactly one cycle, then IDLE.
- A read arriving during DRAIN waits for that drain to finish. On return to IDLE the read is re-checked for a match before issuing.
- Simultaneous upstream write and drain pop in one cycle: both take effect; count is unchanged.
- The upstream address low OFFS_W bits are ignored for compare and on the Memory bus.

Optional Feature:
- Macro WB_STATS_EN.
- Defined: no_write_o, no_coalesce_o and no_fwd_o are 32-bit saturating counters, incremented on each accepted write, each coalesced write, and each forwarded read respectively. Reset to 0.
- Not defined: the ports exist but are tied to 0, and no counter logic is synthesized.

Test Plan:
- Write A=0x0000_1000, D=0x1111..., Memory latency 5 -> up_ready_o pulses the cycle after acceptance. Memory then sees mem_rw_o=1, addr 0x1000, data D, with mem_valid_o held until mem_ready_i, followed by one GAP cycle. Finish with empty_o=1.
- Fill with 4 distinct writes while mem_ready_i is held 0 -> full_o=1. A 5th write gets no up_ready_o. Releasing one mem_ready_i pulse accepts the 5th within 2 cycles.
- Write 0x2000=X, then write 0x2004=Y (same line) while the entry is not the head -> count unchanged, the entry holds Y, and no_coalesce_o=1 (WB_STATS_EN).
- Write 0x3000=Z, then read 0x3000 before it drains -> up_rdata_o=Z the next cycle, no mem read issued, no_fwd_o=1.
- Read 0x4000 with the buffer empty and Memory returning W after 3 cycles -> mem_rw_o=0, and up_ready_o with up_rdata_o=W one cycle after mem_ready_i.
- Assert rst_i during DRAIN with 3 entries -> mem_valid_o drops immediately, empty_o=1, and after reset release no Memory request is issued.

Source files
------------

// File: rtl/l2_write_buffer.sv
// Posted-write buffer between L2 and main memory: acks writebacks early, drains them in
// the background and forwards reads that hit a buffered line. Optional stats: WB_STATS_EN.
module l2_write_buffer #(
  parameter int DEPTH  = 4,
  parameter int LINE_W = 128,
  parameter int OFFS_W = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              up_valid_i,
  input  logic              up_rw_i,
  input  logic [31:0]       up_addr_i,
  input  logic [LINE_W-1:0] up_wdata_i,
  output logic              up_ready_o,
  output logic [LINE_W-1:0] up_rdata_o,
  output logic              mem_valid_o,
  output logic              mem_rw_o,
  output logic [31:0]       mem_addr_o,
  output logic [LINE_W-1:0] mem_wdata_o,
  input  logic              mem_ready_i,
  input  logic [LINE_W-1:0] mem_rdata_i,
  output logic              full_o,
  output logic              empty_o,
  output logic [31:0]       no_write_o,
  output logic [31:0]       no_coalesce_o,
  output logic [31:0]       no_fwd_o
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int TAG_W = 32 - OFFS_W;

  typedef enum logic [1:0] {S_IDLE, S_DRAIN, S_READ, S_GAP} state_t;

  state_t              r_state, w_next;
  logic [TAG_W-1:0]    r_tag  [DEPTH];
  logic [LINE_W-1:0]   r_data [DEPTH];
  logic [PTR_W-1:0]    r_head, r_tail;
  logic [CNT_W-1:0]    r_count;
  logic                r_up_ready;
  logic [LINE_W-1:0]   r_up_rdata;
  logic [TAG_W-1:0]    r_rd_tag;

  logic [TAG_W-1:0]    w_up_tag;
  logic                w_req, w_wr_req, w_rd_req;
  logic                w_wr_hit, w_rd_hit;
  logic [PTR_W-1:0]    w_wr_idx, w_rd_idx, w_idx;
  logic                w_do_coal, w_do_enq, w_do_fwd, w_pop, w_rd_done, w_full;
  logic                w_unused_ok;

  assign w_up_tag    = up_addr_i[31:OFFS_W];
  assign w_unused_ok = ^up_addr_i[OFFS_W-1:0];
  // r_up_ready doubles as the busy flag: the request is still valid during its ack cycle.
  assign w_req    = up_valid_i & ~r_up_ready;
  assign w_wr_req = w_req & up_rw_i;
  assign w_rd_req = w_req & ~up_rw_i;
  assign w_full   = (r_count == CNT_W'(DEPTH));

  // NOTE: every signal written in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    w_wr_hit = 1'b0;
    w_wr_idx = '0;
    w_rd_hit = 1'b0;
    w_rd_idx = '0;
    w_idx    = '0;
    // Scan oldest to youngest so the last hit wins; the head under drain is off-limits to writes.
    for (int i = 0; i < DEPTH; i++) begin
      w_idx = r_head + PTR_W'(i);
      if (CNT_W'(i) < r_count && r_tag[w_idx] == w_up_tag) begin
        w_rd_hit = 1'b1;
        w_rd_idx = w_idx;
        if (!(i == 0 && r_state == S_DRAIN)) begin
          w_wr_hit = 1'b1;
          w_wr_idx = w_idx;
        end
      end
    end
  end

  assign w_do_coal = w_wr_req & w_wr_hit;
  assign w_do_enq  = w_wr_req & ~w_wr_hit & ~w_full;
  assign w_do_fwd  = w_rd_req & w_rd_hit & (r_state == S_IDLE);
  assign w_pop     = (r_state == S_DRAIN) & mem_ready_i;
  assign w_rd_done = (r_state == S_READ) & mem_ready_i;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_rd_req && !w_rd_hit)       w_next = S_READ;
        else if (!w_rd_req && !empty_o)  w_next = S_DRAIN;
      end
      S_DRAIN, S_READ: if (mem_ready_i) w_next = S_GAP;
      default:                          w_next = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_up_ready <= 1'b0;
      r_up_rdata <= '0;
      r_rd_tag   <= '0;
    end else begin
      r_up_ready <= w_do_coal | w_do_enq | w_do_fwd | w_rd_done;
      if (w_do_fwd)       r_up_rdata <= r_data[w_rd_idx];
      else if (w_rd_done) r_up_rdata <= mem_rdata_i;
      if (r_state == S_IDLE && w_next == S_READ) r_rd_tag <= w_up_tag;
      if (w_do_enq) r_tail <= r_tail + 1'b1;
      if (w_pop)    r_head <= r_head + 1'b1;
      case ({w_do_enq, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // NOTE: entry storage is not reset; r_count alone decides which entries are live.
  always_ff @(posedge clk_i) begin
    if (w_do_enq) begin
      r_tag[r_tail]  <= w_up_tag;
      r_data[r_tail] <= up_wdata_i;
    end
    if (w_do_coal) r_data[w_wr_idx] <= up_wdata_i;
  end

  always_comb begin
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    if (r_state == S_DRAIN) begin
      mem_addr_o  = {r_tag[r_head], {OFFS_W{1'b0}}};
      mem_wdata_o = r_data[r_head];
    end else if (r_state == S_READ) begin
      mem_addr_o  = {r_rd_tag, {OFFS_W{1'b0}}};
    end
  end

  assign mem_valid_o = (r_state == S_DRAIN) | (r_state == S_READ);
  assign mem_rw_o    = (r_state == S_DRAIN);
  assign up_ready_o  = r_up_ready;
  assign up_rdata_o  = r_up_rdata;
  assign full_o      = w_full;
  assign empty_o     = (r_count == '0);

`ifdef WB_STATS_EN
  logic [31:0] r_no_write, r_no_coalesce, r_no_fwd;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_no_write    <= '0;
      r_no_coalesce <= '0;
      r_no_fwd      <= '0;
    end else begin
      if ((w_do_enq | w_do_coal) && r_no_write != '1) r_no_write    <= r_no_write + 32'd1;
      if (w_do_coal && r_no_coalesce != '1)           r_no_coalesce <= r_no_coalesce + 32'd1;
      if (w_do_fwd && r_no_fwd != '1)                 r_no_fwd      <= r_no_fwd + 32'd1;
    end
  end

  assign no_write_o    = r_no_write;
  assign no_coalesce_o = r_no_coalesce;
  assign no_fwd_o      = r_no_fwd;
`else
  assign no_write_o    = '0;
  assign no_coalesce_o = '0;
  assign no_fwd_o      = '0;
`endif

endmodule
